// File: rtl/multdiv_arb_pkg.sv
// Shared types and constants for the multdiv arbiter.
// State encoding, op encoding and default datapath width.
package multdiv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
// Ports: req_valid, ptr in; gnt_oh, gnt_idx, gnt_any out.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [PW-1:0] j;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!gnt_any && req_valid[j]) begin
        gnt_any    = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = j;
      end
    end
  end

endmodule

// File: rtl/multdiv_arbiter.sv
// Shares one multdiv unit among N_REQ requesters, round-robin.
// Ports: req_* / resp_* per requester, md_* to multdiv, busy.
module multdiv_arbiter
  import multdiv_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_except,
  output logic [WIDTH-1:0]   md_operandA,
  output logic [WIDTH-1:0]   md_operandB,
  output logic               md_ctrl_Mult,
  output logic               md_ctrl_Div,
  input  logic [WIDTH-1:0]   md_result,
  input  logic               md_except,
  input  logic               md_ready,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic exc_q, exc_d;
  logic [CW-1:0] wd_q, wd_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    exc_d   = exc_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          gnt_d = gnt_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
              op_d  = req_op[i];
              opa_d = req_a[i*WIDTH +: WIDTH];
              opb_d = req_b[i*WIDTH +: WIDTH];
            end
          end
          ptr_d = (gnt_idx == PW'(N_REQ - 1))
                  ? '0 : gnt_idx + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // md_ready beats the watchdog on the abort cycle
        if (md_ready) begin
          res_d   = md_result;
          exc_d   = md_except;
          state_d = ST_RESP;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      wd_q    <= wd_d;
    end
  end

  // reset gates the combinational grant so all outputs read 0
  assign req_ready = (state_q == ST_IDLE && !reset)
                     ? gnt_oh : '0;

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_RESP) resp_valid[gnt_q] = 1'b1;
  end

  assign md_ctrl_Mult = (state_q == ST_ISSUE) && (op_q == OP_MULT);
  assign md_ctrl_Div  = (state_q == ST_ISSUE) && (op_q == OP_DIV);
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign resp_result  = res_q;
  assign resp_except  = exc_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Scoreboard bench for multdiv_arbiter with a behavioural multdiv.
// Directed vectors; monitor pops expected responses on handshake.
module tb_multdiv_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid, req_op, req_ready;
  logic [N-1:0] resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] resp_result, md_operandA, md_operandB;
  logic resp_except, md_ctrl_Mult, md_ctrl_Div, busy;
  logic [W-1:0] md_result = '0;
  logic md_except = 1'b0;
  logic md_ready = 1'b0;

  typedef struct {
    int idx;
    logic op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic exc;
  } vec_t;

  vec_t pend0[$];
  vec_t pend1[$];
  vec_t sb_q[$];
  int glog[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_mult = 0;
  int n_div = 0;
  int t_issue = 0;
  int t_resp = 0;
  logic [N-1:0] rv_prev = '0;

  int lat = 3;
  bit hang = 1'b0;
  int cnt = 0;
  logic signed [W-1:0] ma = '0;
  logic signed [W-1:0] mb = '0;
  logic mop = 1'b0;

  multdiv_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_except  (resp_except),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .md_ctrl_Mult (md_ctrl_Mult),
    .md_ctrl_Div  (md_ctrl_Div),
    .md_result    (md_result),
    .md_except    (md_except),
    .md_ready     (md_ready),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // behavioural multdiv: ready pulses lat edges after the start pulse
  always @(posedge clock) begin
    if (md_ctrl_Mult || md_ctrl_Div) begin
      ma       <= md_operandA;
      mb       <= md_operandB;
      mop      <= md_ctrl_Div;
      cnt      <= hang ? 0 : lat;
      md_ready <= 1'b0;
    end else if (cnt > 0) begin
      cnt      <= cnt - 1;
      md_ready <= (cnt == 1);
      if (cnt == 1) begin
        if (!mop) begin
          md_result <= ma * mb;
          md_except <= 1'b0;
        end else if (mb == 0) begin
          md_result <= '1;
          md_except <= 1'b1;
        end else begin
          md_result <= ma / mb;
          md_except <= 1'b0;
        end
      end
    end else begin
      md_ready <= 1'b0;
    end
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int idx, logic op,
      logic [W-1:0] a, logic [W-1:0] b,
      logic [W-1:0] r, logic x);
    vec_t v;
    v.idx = idx;
    v.op  = op;
    v.a   = a;
    v.b   = b;
    v.res = r;
    v.exc = x;
    return v;
  endfunction

  task automatic push(vec_t v);
    if (v.idx == 0) pend0.push_back(v);
    else pend1.push_back(v);
  endtask

  task automatic drive();
    req_valid = '0;
    if (pend0.size() != 0) begin
      req_valid[0]   = 1'b1;
      req_op[0]      = pend0[0].op;
      req_a[W-1:0]   = pend0[0].a;
      req_b[W-1:0]   = pend0[0].b;
    end
    if (pend1.size() != 0) begin
      req_valid[1]   = 1'b1;
      req_op[1]      = pend1[0].op;
      req_a[2*W-1:W] = pend1[0].a;
      req_b[2*W-1:W] = pend1[0].b;
    end
  endtask

  task automatic driver();
    logic [N-1:0] acc;
    forever begin
      @(negedge clock);
      acc = req_ready & req_valid;
      if (req_ready != 0)
        chk("req_ready_onehot_idle",
            {62'b0, $onehot(req_ready), busy}, 64'h2);
      @(posedge clock);
      #1;
      if (acc[0] && pend0.size() != 0) begin
        sb_q.push_back(pend0.pop_front());
        glog.push_back(0);
      end
      if (acc[1] && pend1.size() != 0) begin
        sb_q.push_back(pend1.pop_front());
        glog.push_back(1);
      end
      drive();
    end
  endtask

  task automatic monitor();
    vec_t e;
    logic [N-1:0] eoh;
    forever begin
      @(negedge clock);
      if (md_ctrl_Mult) n_mult++;
      if (md_ctrl_Div) n_div++;
      if (md_ctrl_Mult || md_ctrl_Div) begin
        t_issue = cyc;
        chk("ctrl_exclusive",
            {63'b0, md_ctrl_Mult & md_ctrl_Div}, 64'h0);
      end
      if (resp_valid != 0 && rv_prev == 0) t_resp = cyc;
      rv_prev = resp_valid;
      if ((resp_valid & resp_ready) != 0) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_resp: resp_valid %b, none expected",
                   resp_valid);
        end else begin
          e = sb_q.pop_front();
          eoh = '0;
          eoh[e.idx] = 1'b1;
          chk("resp", {29'b0, resp_valid, resp_except, resp_result},
              {29'b0, eoh, e.exc, e.res});
        end
      end
    end
  endtask

  task automatic wait_drain(string nm);
    int k = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 ||
            sb_q.size() != 0 || busy) && k < 400) begin
      @(negedge clock);
      k++;
    end
    if (k >= 400) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_drain: still busy after 400 cycles, required idle",
               nm);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m0, d0, k, r0;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    #1 reset = 1'b1;
    #1;
    chk("rst_ctrl", {57'b0, busy, resp_valid, req_ready,
        md_ctrl_Mult, md_ctrl_Div, resp_except}, 64'h0);
    chk("rst_operands", {md_operandA, md_operandB}, 64'h0);
    chk("rst_result", {32'b0, resp_result}, 64'h0);
    fork
      driver();
      monitor();
    join_none
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // 1: multiply 7 * -6 with 33-cycle multdiv
    lat = 33;
    m0 = n_mult;
    d0 = n_div;
    push(mk(0, 1'b0, 7, -6, -42, 1'b0));
    wait_drain("t1");
    chk("t1_mult_pulses", 64'(n_mult - m0), 64'd1);
    chk("t1_div_pulses", 64'(n_div - d0), 64'd0);
    chk("t1_latency", 64'(t_resp - t_issue), 64'd35);

    // 2: divide by zero from requester 1
    lat = 5;
    m0 = n_mult;
    d0 = n_div;
    push(mk(1, 1'b1, 100, 0, 32'hFFFF_FFFF, 1'b1));
    wait_drain("t2");
    chk("t2_div_pulses", 64'(n_div - d0), 64'd1);
    chk("t2_mult_pulses", 64'(n_mult - m0), 64'd0);

    // 3: both requesters streaming, grants alternate
    lat = 2;
    glog.delete();
    push(mk(0, 1'b0, 2, 3, 6, 1'b0));
    push(mk(0, 1'b0, 5, -5, -25, 1'b0));
    push(mk(0, 1'b0, -8, -8, 64, 1'b0));
    push(mk(0, 1'b0, 1000, 1000, 1000000, 1'b0));
    push(mk(1, 1'b1, 100, 7, 14, 1'b0));
    push(mk(1, 1'b1, -100, 7, -14, 1'b0));
    push(mk(1, 1'b1, 9, -2, -4, 1'b0));
    push(mk(1, 1'b1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1'b0));
    wait_drain("t3");
    chk("t3_grant_count", 64'(glog.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("t3_grant_order",
          64'((i < glog.size()) ? glog[i] : 99), 64'(i % 2));

    // 4: multdiv hangs, watchdog aborts
    hang = 1'b1;
    push(mk(0, 1'b0, 3, 3, 0, 1'b1));
    wait_drain("t4");
    chk("t4_timeout_latency", 64'(t_resp - t_issue), 64'(TO + 1));
    hang = 1'b0;

    // 5: response back-pressure, other resp_ready bit ignored
    lat = 2;
    resp_ready = 2'b10;
    push(mk(0, 1'b0, 3, 4, 12, 1'b0));
    k = 0;
    while (resp_valid == 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("t5_resp_seen", {62'b0, resp_valid}, 64'h1);
    push(mk(1, 1'b1, 20, -3, -6, 1'b0));
    m0 = n_mult + n_div;
    repeat (10) begin
      @(negedge clock);
      chk("t5_hold", {26'b0, resp_valid, req_ready, busy,
          resp_except, resp_result},
          {26'b0, 2'b01, 2'b00, 1'b1, 1'b0, 32'd12});
    end
    chk("t5_no_issue", 64'(n_mult + n_div - m0), 64'd0);
    @(posedge clock);
    #1 resp_ready = '1;
    @(posedge clock);
    #2;
    chk("t5_done", {61'b0, resp_valid, busy}, 64'h0);
    wait_drain("t5");

    // 6: reset mid-WAIT, stale md_ready afterwards
    lat = 20;
    push(mk(0, 1'b0, 5, 5, 25, 1'b0));
    k = 0;
    while (!busy && k < 20) begin
      @(negedge clock);
      k++;
    end
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_ctrl", {57'b0, busy, resp_valid, req_ready,
        md_ctrl_Mult, md_ctrl_Div, resp_except}, 64'h0);
    chk("t6_rst_operands", {md_operandA, md_operandB}, 64'h0);
    chk("t6_rst_result", {32'b0, resp_result}, 64'h0);
    sb_q.delete();
    r0 = t_resp;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    chk("t6_no_resp", 64'(t_resp - r0), 64'd0);
    chk("t6_idle", {63'b0, busy}, 64'h0);
    lat = 3;
    glog.delete();
    push(mk(0, 1'b0, 7, 7, 49, 1'b0));
    push(mk(1, 1'b1, -9, 3, -3, 1'b0));
    wait_drain("t6");
    chk("t6_first_grant",
        64'((glog.size() > 0) ? glog[0] : 99), 64'd0);
    chk("t6_second_grant",
        64'((glog.size() > 1) ? glog[1] : 99), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_arbiter.md
# multdiv_arbiter

Shares one `multdiv` unit between `N_REQ` requesters, such as the processor execute stage and the hash-support datapath. It arbitrates round-robin, sequences each operation, and collects the result. Each operation gets a one-cycle `ctrl_Mult`/`ctrl_Div` pulse, operands held stable until `ready`, and the result returned to the winning requester under a valid/ready handshake. A watchdog converts a hung operation into an exception response.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `WIDTH`, default 32: operand and result width.
- `TIMEOUT`, default 64: WAIT cycles allowed before abort; must be ≥ 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in N_REQ: request pending, one bit per requester.
- `req_op` in N_REQ: per requester; 0 = multiply, 1 = divide.
- `req_a` in N_REQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_b` in N_REQ*WIDTH: operand B, same packing.
- `req_ready` out N_REQ: one-hot acceptance pulse.
- `resp_valid` out N_REQ: one-hot; response pending for requester i.
- `resp_ready` in N_REQ: requester consumes its response.
- `resp_result` out WIDTH: signed result, shared bus.
- `resp_except` out 1: exception flag, shared.
- `md_operandA`, `md_operandB` out WIDTH: to multdiv.
- `md_ctrl_Mult`, `md_ctrl_Div` out 1: one-cycle start pulses to multdiv.
- `md_result` in WIDTH, `md_except` in 1, `md_ready` in 1: from multdiv.
- `busy` out 1: high in every state except IDLE.

## Operation
State machine IDLE → ISSUE → WAIT → RESP → IDLE.

- **IDLE**
  - Grant `g` = first i with `req_valid[i]`, searching from `ptr` upward with wrap.
  - Same cycle: `req_ready[g]`=1.
  - On the clock edge: latch `req_a[g]`, `req_b[g]`, `req_op[g]` into `md_operandA`/`md_operandB`/op register; set `ptr` = (g+1) mod N_REQ; go to ISSUE.
  - No `req_valid` set: stay in IDLE; `ptr` unchanged.
- **ISSUE**
  - Exactly one of `md_ctrl_Mult`/`md_ctrl_Div` is high for exactly one cycle, chosen by the latched op.
  - `md_ready` is ignored here, so stale ready from a previous op cannot complete this one.
  - Clear the watchdog counter; go to WAIT.
- **WAIT**
  - Operands held stable.
  - On `md_ready`=1: capture `md_result`→`resp_result` and `md_except`→`resp_except`; go to RESP.
  - Watchdog reaches `TIMEOUT` without `md_ready`: `resp_result`=0, `resp_except`=1; go to RESP.
- **RESP**
  - `resp_valid[g]`=1, held with `resp_result`/`resp_except` stable until `resp_ready[g]`=1.
  - Then return to IDLE.
  - `resp_ready` bits of other requesters are ignored.

Arithmetic: the result is passed through unmodified, with multdiv's overflow and divide-by-zero reported through `except`. The arbiter performs no sign or width conversion.

Fairness: after requester i is served, i has lowest priority. With all N_REQ requesting continuously, grants rotate 0,1,…,N_REQ−1.

## Timing
- Accept at edge 0.
- Start pulse during cycle 1.
- multdiv asserts `md_ready` in cycle k ≥ 2.
- `resp_valid` is high from cycle k+1.
- Minimum occupancy: 4 cycles per op including the RESP handshake.
- One operation in flight at a time. `req_ready` is never high outside IDLE.
- `req_valid` and `resp_ready` arriving in the same cycle for different requesters: the response completes first; the new request waits for IDLE.
- Requester may drop `req_valid` before grant; no request is latched.
- Reset at any point, including mid-WAIT:
  - Immediately: state=IDLE, `ptr`=0, watchdog=0, all outputs 0.
  - The in-flight op is discarded and produces no response.
  - multdiv is not reset by this block; its next start pulse restarts it.
- Watchdog: counts WAIT cycles; abort on the cycle the count equals `TIMEOUT`. `md_ready` in that same cycle wins, giving a normal response.

## Structure
- Package `multdiv_arb_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - op encoding constants `OP_MULT`=0, `OP_DIV`=1;
  - default `WIDTH`.
- Sub-module `rr_arbiter`:
  - purely combinational;
  - inputs: `req_valid`, `ptr`;
  - outputs: one-hot grant, grant index, any-grant.
- Top level holds the FSM, operand/result registers, `ptr`, and the watchdog counter.

## Test plan
1. Req0 multiply 7 × −6, multdiv model with 33-cycle latency → `md_ctrl_Mult` pulses once, `resp_valid[0]` with `resp_result`=−42, `resp_except`=0.
2. Req1 divide 100 / 0 → `md_ctrl_Div` pulse, `resp_result`=multdiv output, `resp_except`=1, routed only to `resp_valid[1]`.
3. Both requesters valid continuously for 4 ops each → grant order 0,1,0,1,… with no starvation; `req_ready` one-hot and only in IDLE.
4. `md_ready` tied low, `TIMEOUT`=64 → `resp_valid` exactly 64 WAIT cycles after ISSUE, `resp_result`=0, `resp_except`=1.
5. `resp_ready` held low 10 cycles in RESP → result stable, no new grant, `busy`=1; completes the cycle `resp_ready` rises.
6. Assert `reset` mid-WAIT, then a stale `md_ready` arrives → all outputs 0, no response issued; next request served normally with grant priority restarting at requester 0.
